// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver state encoding, oversampling constants
// and bus register addresses, used by both the receive and transmit halves.
package spart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID        = 8;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;

endpackage

// File: rtl/spart_rx_if.sv
// Bus-side signal bundle of the SPART receiver: serial line, baud enable,
// register access controls and the received byte with its status flags.
interface spart_rx_if;

    logic       RxD;
    logic       Enable;
    logic       IORW;
    logic [1:0] IOADDR;
    logic [7:0] rx_data;
    logic       RDA;
    logic       FE;
    logic       OE;

    modport master (
        output RxD, Enable, IORW, IOADDR,
        input  rx_data, RDA, FE, OE
    );

    modport slave (
        input  RxD, Enable, IORW, IOADDR,
        output rx_data, RDA, FE, OE
    );

endinterface

// File: rtl/spart_sync.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so an idle-high line does not look like a start edge.
module spart_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spart_rx.sv
// SPART receive half: recovers 8N1 frames from RxD using the 16x baud enable
// and holds the last good byte with data-available and sticky error flags.
module spart_rx
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    spart_rx_if.slave  bus
);

    localparam logic [3:0] TICK_MID  = 4'(MID - 1);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    logic      rxs;
    rx_state_e state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bitCnt_q, bitCnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rxData_q, rxData_d;
    logic       rda_q, rda_d;
    logic       fe_q, fe_d;
    logic       oe_q, oe_d;
    logic       dataRead, statusRead;
    logic       stopGood, stopBad;

    spart_sync #(.RESET_VAL(1'b1)) rxSync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.RxD),
        .q_o (rxs)
    );

    assign dataRead   = bus.IORW && (bus.IOADDR == ADDR_DATA);
    assign statusRead = bus.IORW && (bus.IOADDR == ADDR_STATUS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tick_q   <= 4'd0;
            bitCnt_q <= 3'd0;
            shreg_q  <= 8'h00;
            rxData_q <= 8'h00;
            rda_q    <= 1'b0;
            fe_q     <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bitCnt_q <= bitCnt_d;
            shreg_q  <= shreg_d;
            rxData_q <= rxData_d;
            rda_q    <= rda_d;
            fe_q     <= fe_d;
            oe_q     <= oe_d;
        end
    end

    // Frame sequencing; the 4-bit tick counter wraps from 15 to 0 on its own.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bitCnt_d = bitCnt_q;
        shreg_d  = shreg_q;
        stopGood = 1'b0;
        stopBad  = 1'b0;
        if (bus.Enable) begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        tick_d  = 4'd0;
                    end
                end
                START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d = 4'd0;
                        if (!rxs) begin
                            state_d  = DATA;
                            bitCnt_d = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                DATA: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        shreg_d  = {rxs, shreg_q[7:1]};
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
                STOP: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        if (rxs) begin
                            stopGood = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            stopBad = 1'b1;
                            state_d = BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Reads clear first so that a completing frame or error in the same cycle wins.
    always_comb begin
        rxData_d = rxData_q;
        rda_d    = rda_q;
        fe_d     = fe_q;
        oe_d     = oe_q;
        if (dataRead) begin
            rda_d = 1'b0;
        end
        if (statusRead) begin
            fe_d = 1'b0;
            oe_d = 1'b0;
        end
        if (stopGood) begin
            rxData_d = shreg_q;
            rda_d    = 1'b1;
            if (rda_q && !dataRead) begin
                oe_d = 1'b1;
            end
        end
        if (stopBad) begin
            fe_d = 1'b1;
        end
    end

    assign bus.rx_data = rxData_q;
    assign bus.RDA     = rda_q;
    assign bus.FE      = fe_q;
    assign bus.OE      = oe_q;

endmodule

// File: tb/tb_spart_rx.sv
// Scoreboard bench for spart_rx: every expected change of the visible outputs
// is queued by the driver and matched by a monitor when the outputs change.
module tb_spart_rx;

    import spart_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       rda;
        logic       fe;
        logic       oe;
    } outVec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   enPeriod = 1;
    int   vectors = 0;
    int   miscompares = 0;
    outVec_t expQ[$];
    outVec_t model;

    spart_rx_if bus();

    spart_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic outVec_t observed();
        outVec_t v;
        v.data = bus.rx_data;
        v.rda  = bus.RDA;
        v.fe   = bus.FE;
        v.oe   = bus.OE;
        return v;
    endfunction

    task automatic checkOutput(input string name, input outVec_t got, input outVec_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got data=%h RDA=%b FE=%b OE=%b, expected data=%h RDA=%b FE=%b OE=%b",
                     name, got.data, got.rda, got.fe, got.oe, exp.data, exp.rda, exp.fe, exp.oe);
        end
    endtask

    task automatic pushIfChanged(input outVec_t next);
        if (next != model) begin
            expQ.push_back(next);
            model = next;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle register access; the reference effect is queued before it is issued.
    task automatic busOp(input logic iorw, input logic [1:0] addr);
        outVec_t next;
        next = model;
        if (iorw && addr == ADDR_DATA) next.rda = 1'b0;
        if (iorw && addr == ADDR_STATUS) begin
            next.fe = 1'b0;
            next.oe = 1'b0;
        end
        pushIfChanged(next);
        bus.IORW   = iorw;
        bus.IOADDR = addr;
        @(negedge clk);
        bus.IORW   = 1'b0;
        bus.IOADDR = 2'b00;
    endtask

    // Drives one 8N1 frame; readCycle (if >= 0) is the frame's completion cycle,
    // rstCycle (if >= 0) aborts the frame with a reset pulse.
    task automatic applyStimulus(input logic [7:0] data, input logic stopVal, input int bitClks,
                                 input int readCycle, input int rstCycle);
        logic [9:0] bits;
        outVec_t    next;
        bits = {stopVal, data, 1'b0};
        for (int i = 0; i < 10 * bitClks; i++) begin
            if (i == rstCycle) begin
                pushIfChanged('0);
                rst     = 1'b1;
                bus.RxD = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (i == 9 * bitClks) begin
                next = model;
                if (stopVal) begin
                    next.data = data;
                    next.rda  = 1'b1;
                    next.oe   = model.oe | (model.rda && readCycle < 0);
                end else begin
                    next.fe = 1'b1;
                end
                pushIfChanged(next);
            end
            bus.RxD = bits[i / bitClks];
            if (i == readCycle) begin
                bus.IORW   = 1'b1;
                bus.IOADDR = ADDR_DATA;
            end else begin
                bus.IORW   = 1'b0;
                bus.IOADDR = 2'b00;
            end
            @(negedge clk);
        end
        bus.RxD    = 1'b1;
        bus.IORW   = 1'b0;
        bus.IOADDR = 2'b00;
    endtask

    initial begin
        int cnt;
        cnt = 0;
        bus.Enable = 1'b0;
        forever begin
            @(negedge clk);
            bus.Enable = (cnt == 0);
            cnt = (cnt + 1 >= enPeriod) ? 0 : cnt + 1;
        end
    end

    initial begin
        outVec_t last;
        outVec_t now;
        @(negedge clk);
        last = observed();
        forever begin
            @(negedge clk);
            now = observed();
            if (now !== last) begin
                if (expQ.size() == 0) checkOutput("unexpected_change", now, model);
                else checkOutput("scoreboard", now, expQ.pop_front());
                last = now;
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, queue depth %0d", expQ.size());
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       s;
        bus.RxD    = 1'b1;
        bus.IORW   = 1'b0;
        bus.IOADDR = 2'b00;
        model      = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_values", observed(), '0);
        rst = 1'b0;
        idle(5);

        applyStimulus(8'h55, 1'b1, 16, -1, -1);
        idle(5);
        busOp(1'b1, ADDR_DATA);
        idle(5);

        bus.RxD = 1'b0;
        idle(4);
        bus.RxD = 1'b1;
        idle(20);
        applyStimulus(8'hA3, 1'b1, 16, -1, -1);
        idle(3);
        busOp(1'b1, ADDR_DATA);
        idle(3);

        applyStimulus(8'h0F, 1'b0, 16, -1, -1);
        bus.RxD = 1'b0;
        idle(40);
        bus.RxD = 1'b1;
        idle(200);
        busOp(1'b1, ADDR_STATUS);
        idle(5);

        applyStimulus(8'h12, 1'b1, 16, -1, -1);
        applyStimulus(8'h34, 1'b1, 16, -1, -1);
        idle(3);
        busOp(1'b1, ADDR_STATUS);
        busOp(1'b1, ADDR_DATA);
        idle(5);

        applyStimulus(8'h12, 1'b1, 16, -1, -1);
        applyStimulus(8'h34, 1'b1, 16, 154, -1);
        idle(3);
        busOp(1'b1, ADDR_DATA);
        idle(5);

        applyStimulus(8'hFF, 1'b1, 16, -1, 60);
        idle(30);
        applyStimulus(8'h81, 1'b1, 16, -1, -1);
        idle(3);
        busOp(1'b1, ADDR_DATA);
        idle(5);

        enPeriod = 5;
        idle(10);
        applyStimulus(8'hC6, 1'b1, 82, -1, -1);
        idle(40);
        busOp(1'b1, ADDR_DATA);
        idle(10);
        applyStimulus(8'hC6, 1'b1, 78, -1, -1);
        idle(40);
        busOp(1'b1, ADDR_DATA);
        enPeriod = 1;
        idle(10);

        for (int n = 0; n < 16; n++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 5) != 0);
            applyStimulus(d, s, 16, -1, -1);
            if (!s) idle(40);
            else idle($urandom_range(0, 3));
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                busOp(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            end
        end

        idle(50);
        while (expQ.size() > 0) begin
            outVec_t e;
            e = expQ.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL missing_change: expected data=%h RDA=%b FE=%b OE=%b never appeared",
                     e.data, e.rda, e.fe, e.oe);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
